// File: rtl/ram_rd_check.sv
// Read-back checker for the RAM pattern generator: snoops en/we/addr, realigns each
// qualifying read to its data after RD_LAT clocks and checks it against RAM[a] = a.
module ram_rd_check #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 ram_en,
    input  logic                 ram_we,
    input  logic [ADDR_W-1:0]    ram_addr,
    input  logic [DATA_W-1:0]    ram_rdata,
    input  logic                 chk_clr,
    output logic                 rd_valid,
    output logic                 err,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic [DATA_W-1:0]    first_err_data,
    output logic                 pass_done,
    output logic                 pass_ok,
    output logic [15:0]          pass_cnt
);

    localparam logic [ADDR_W:0] WR_FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t                          state, state_nxt;
    logic [ADDR_W:0]                 wr_cnt, wr_cnt_nxt;
    logic                            wr_issue, rd_issue;
    logic                            rd_checked, idle_entry;
    logic [RD_LAT-1:0]               pipe_vld;
    logic [RD_LAT-1:0][ADDR_W-1:0]   pipe_addr;
    logic                            tail_vld;
    logic [ADDR_W-1:0]               tail_addr;
    logic                            mis_now, pass_now;
    logic                            pass_err;
    logic                            first_seen;

    assign wr_issue = ram_en & ram_we;
    assign rd_issue = ram_en & ~ram_we;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= IDLE;
            wr_cnt <= '0;
        end else begin
            state  <= state_nxt;
            wr_cnt <= wr_cnt_nxt;
        end
    end

    // Reads only qualify once a complete write sweep has filled the RAM.
    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        rd_checked = 1'b0;
        idle_entry = 1'b0;
        case (state)
            IDLE: begin
                if (wr_issue) begin
                    state_nxt  = WRITE;
                    wr_cnt_nxt = (ADDR_W+1)'(1);
                end
            end
            WRITE: begin
                if (wr_issue) begin
                    if (wr_cnt != WR_FULL)
                        wr_cnt_nxt = wr_cnt + (ADDR_W+1)'(1);
                end else if (rd_issue) begin
                    if (wr_cnt == WR_FULL) begin
                        state_nxt  = READ;
                        rd_checked = 1'b1;
                    end else begin
                        state_nxt  = IDLE;
                        idle_entry = 1'b1;
                    end
                end
            end
            READ: begin
                if (rd_issue) begin
                    rd_checked = 1'b1;
                end else if (wr_issue) begin
                    state_nxt  = WRITE;
                    wr_cnt_nxt = (ADDR_W+1)'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pipe_vld  <= '0;
            pipe_addr <= '0;
        end else begin
            pipe_vld[0]  <= rd_checked;
            pipe_addr[0] <= ram_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    assign tail_vld  = pipe_vld[RD_LAT-1];
    assign tail_addr = pipe_addr[RD_LAT-1];
    assign mis_now   = tail_vld & (ram_rdata != DATA_W'(tail_addr));
    assign pass_now  = tail_vld & (&tail_addr);

    // A clear coinciding with an event is applied first, then the event is recorded.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_valid       <= 1'b0;
            err            <= 1'b0;
            pass_done      <= 1'b0;
            err_flag       <= 1'b0;
            err_cnt        <= '0;
            first_seen     <= 1'b0;
            first_err_addr <= '0;
            first_err_data <= '0;
            pass_ok        <= 1'b0;
            pass_cnt       <= '0;
            pass_err       <= 1'b0;
        end else begin
            rd_valid  <= tail_vld;
            err       <= mis_now;
            pass_done <= pass_now;
            if (chk_clr) begin
                err_flag       <= 1'b0;
                err_cnt        <= '0;
                first_seen     <= 1'b0;
                first_err_addr <= '0;
                first_err_data <= '0;
                pass_ok        <= 1'b0;
                pass_cnt       <= '0;
            end
            if (mis_now) begin
                err_flag <= 1'b1;
                if (chk_clr)
                    err_cnt <= ERR_CNT_W'(1);
                else if (err_cnt != '1)
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                if (!first_seen || chk_clr) begin
                    first_seen     <= 1'b1;
                    first_err_addr <= tail_addr;
                    first_err_data <= ram_rdata;
                end
            end
            if (pass_now) begin
                pass_ok <= ~(pass_err | mis_now);
                if (chk_clr)
                    pass_cnt <= 16'd1;
                else if (pass_cnt != 16'hFFFF)
                    pass_cnt <= pass_cnt + 16'd1;
            end
            if (pass_now || idle_entry)
                pass_err <= 1'b0;
            else if (mis_now)
                pass_err <= 1'b1;
        end
    end

endmodule

// File: doc/ram_rd_check.md
Name: ram_rd_check

Overview:
- Downstream checker for the single-port RAM exercised by the RAM read/write pattern generator.
- Snoops the generator's control bus (en/we/addr) and the RAM read data, and realigns each read to its data after the RAM read latency.
- Compares each read against the written pattern (RAM[a] = a, zero-extended), accumulates error statistics and reports a per-pass verdict.
- Drives status LEDs / ILA probes in the top level.

Parameters:
- ADDR_W, 5: RAM address width; a full pass covers 2^ADDR_W addresses.
- DATA_W, 8: RAM data width; ADDR_W <= DATA_W.
- RD_LAT, 1: RAM read latency in clocks; legal values 1..3.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous active-high reset.
- ram_en  in  1  RAM enable from generator.
- ram_we  in  1  RAM write select from generator (1 = write, 0 = read).
- ram_addr  in  ADDR_W  RAM address from generator.
- ram_rdata  in  DATA_W  RAM read data port.
- chk_clr  in  1  single-cycle clear of statistics.
- rd_valid  out  1  one-cycle strobe per checked read.
- err  out  1  one-cycle mismatch strobe, aligned with rd_valid.
- err_flag  out  1  sticky mismatch flag.
- err_cnt  out  ERR_CNT_W  saturating mismatch count.
- first_err_addr  out  ADDR_W  address of first mismatch since reset/clear.
- first_err_data  out  DATA_W  data read at first mismatch.
- pass_done  out  1  one-cycle strobe when a pass completes.
- pass_ok  out  1  verdict of the last completed pass.
- pass_cnt  out  16  saturating count of completed passes.

Behaviour:
- Interface: one clock, sys_clk; reset sys_rst is synchronous and active-high.
- Reset: every output 0, FSM in IDLE, delay pipeline cleared, write counter 0, and the per-pass error bit cleared.
- Reset mid-operation: in-flight reads are discarded; no strobe is produced for them.
- Issue classification, sampled at edge n:
  - Write issue: ram_en=1, ram_we=1.
  - Read issue: ram_en=1, ram_we=0.
  - ram_en=0: no issue.
- FSM states: IDLE, WRITE, READ.
  - IDLE: a write issue goes to WRITE with wr_cnt=1. Read issues are ignored, since RAM contents are unknown.
  - WRITE: each write issue increments wr_cnt, saturating at 2^ADDR_W. On a read issue, go to READ if wr_cnt == 2^ADDR_W, else go to IDLE; that read is checked only if READ is entered.
  - READ: each read issue is checked. On a write issue, go to WRITE with wr_cnt=1.
  - ram_en=0 cycles: state holds.
- Alignment:
  - A checked read issued at edge n pushes {valid, addr} into an RD_LAT-deep shift register.
  - ram_rdata is sampled at edge n+RD_LAT and compared with the expected value {zeros, addr}.
  - rd_valid, err and pass_done are registered; they are high for exactly the one cycle following edge n+RD_LAT.
  - Reads already in flight complete even if the FSM leaves READ or ram_en drops.
- Mismatch handling:
  - err=1 when rdata != expected.
  - err_flag is set and stays set.
  - err_cnt increments, saturating at all-ones.
  - On the first mismatch since reset/clear, load first_err_addr and first_err_data; later mismatches do not overwrite them.
- Pass completion:
  - A pass completes when the checked read of address all-ones produces its strobe; pass_done pulses in that same cycle.
  - pass_ok is loaded in that cycle with "no mismatch on any checked read since the previous pass_done or IDLE entry", including the current read. It holds until the next pass_done.
  - pass_cnt increments, saturating at 0xFFFF.
  - The per-pass error bit is cleared after pass_done and on IDLE entry.
- chk_clr:
  - Clears err_flag, err_cnt, first_err_*, pass_cnt and pass_ok in the next cycle.
  - Does not affect the FSM, the pipeline or the per-pass error bit.
  - If a mismatch or pass_done coincides with chk_clr, clear is applied first and the event is then recorded: err_cnt=1, first_err loaded, pass_cnt=1.

Test Plan:
- Nominal, RD_LAT=1:
  - Stimulus: 32 writes of a→a, then 32 reads of addresses 0..31 with a correct model RAM.
  - Required: 32 rd_valid strobes, each 1 cycle after the data edge; pass_done coincident with the addr-31 strobe; pass_ok=1, pass_cnt=1, err_cnt=0.
- Single corruption:
  - Stimulus: the model returns 0xA5 at addr 7.
  - Required: err with rd_valid for addr 7 only; err_flag=1, err_cnt=1, first_err_addr=7, first_err_data=0xA5, pass_ok=0. The next clean pass gives pass_ok=1 with err_flag still 1.
- Saturation and first-error hold:
  - Stimulus: a model always returning 0xFF over 10 passes (320 mismatches).
  - Required: err_cnt=255; first_err_addr=0, first_err_data=0xFF, unchanged.
- Incomplete write phase:
  - Stimulus: 20 writes, then reads.
  - Required: FSM goes to IDLE; no rd_valid or pass_done until after a new full 32-write phase.
- Latency and gaps, RD_LAT=3:
  - Stimulus: ram_en toggled low every other cycle during reads.
  - Required: every read strobed exactly 3 cycles plus 1 after issue, none dropped or duplicated; pass_ok=1.
- Clear and reset collisions:
  - Stimulus: chk_clr coincident with a mismatch strobe.
  - Required: err_cnt=1 and first_err reloaded.
  - Stimulus: sys_rst asserted with 2 reads in flight.
  - Required: all outputs 0 the next cycle and no late strobes.
